// File: rtl/hazard_stall_control_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: register address width,
// divider defaults, and the divide-timer state encoding.
package hazard_stall_control_pkg;

  localparam int REG_ADDR_WIDTH     = 5;
  localparam int DIV_CYCLES_DEFAULT = 32;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_t;

  // An ID source operand depends on the EX destination.
  function automatic logic src_match(
    input logic                      read_en,
    input logic [REG_ADDR_WIDTH-1:0] src,
    input logic [REG_ADDR_WIDTH-1:0] dst
  );
    return read_en && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_div_timer.sv
// Tracks a multi-cycle divide occupying EX: holds the pipeline for DIV_CYCLES-1 cycles
// and pulses div_done in the release cycle.
module hazard_div_timer
  import hazard_stall_control_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int CNT_WIDTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_start,
  output logic       div_busy,
  output logic       div_done,
  output div_state_t state
);

  div_state_t           next_state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] next_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // The entry cycle already stalls, so the counter covers the remaining DIV_CYCLES-2 stall cycles.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    div_busy   = 1'b0;
    div_done   = 1'b0;
    case (state)
      RUN: begin
        if (div_start) begin
          next_state = DIV_BUSY;
          next_cnt   = CNT_WIDTH'(DIV_CYCLES - 2);
          div_busy   = 1'b1;
        end
      end
      DIV_BUSY: begin
        if (cnt != '0) begin
          next_cnt = cnt - 1'b1;
          div_busy = 1'b1;
        end else begin
          div_done   = 1'b1;
          next_state = RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

endmodule

// File: rtl/hazard_stall_control.sv
// Pipeline stall/bubble/flush generator for load-use hazards, the multi-cycle divider
// and taken branches, plus a saturating stall-cycle counter.
module hazard_stall_control
  import hazard_stall_control_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int CNT_WIDTH  = 8,
  parameter int PERF_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] reg_data_1_addr_ID,
  input  logic [REG_ADDR_WIDTH-1:0] reg_data_2_addr_ID,
  input  logic                      read_1_ID,
  input  logic                      read_2_ID,
  input  logic [REG_ADDR_WIDTH-1:0] target_EX,
  input  logic                      WriteReg_EX,
  input  logic                      MemRead_EX,
  input  logic                      div_start_EX,
  input  logic                      branch_taken_ID,
  input  logic                      perf_clear,
  output logic                      stall_PC,
  output logic                      stall_IF_ID,
  output logic                      stall_ID_EX,
  output logic                      flush_IF_ID,
  output logic                      flush_ID_EX,
  output logic                      flush_EX_MEM,
  output logic                      div_busy,
  output logic                      div_done,
  output logic [PERF_WIDTH-1:0]     stall_count
);

  logic       timer_busy;
  logic       timer_done;
  div_state_t div_state;
  logic       load_use;

  hazard_div_timer #(
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_div_timer (
    .clk      (clk),
    .rst      (rst),
    .div_start(div_start_EX),
    .div_busy (timer_busy),
    .div_done (timer_done),
    .state    (div_state)
  );

  // A bubble in EX has MemRead_EX=0, so a single bubble always clears the hazard.
  assign load_use = MemRead_EX && WriteReg_EX && (target_EX != '0) &&
                    (src_match(read_1_ID, reg_data_1_addr_ID, target_EX) ||
                     src_match(read_2_ID, reg_data_2_addr_ID, target_EX));

  // Priority: divide stall, then load-use (RUN only), then branch squash; all forced low in reset.
  always_comb begin
    stall_PC     = 1'b0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    div_busy     = 1'b0;
    div_done     = 1'b0;
    if (!rst) begin
      div_done = timer_done;
      if (timer_busy) begin
        stall_PC     = 1'b1;
        stall_IF_ID  = 1'b1;
        stall_ID_EX  = 1'b1;
        flush_EX_MEM = 1'b1;
        div_busy     = 1'b1;
      end else if (load_use && (div_state == RUN)) begin
        stall_PC    = 1'b1;
        stall_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end else if (branch_taken_ID) begin
        flush_IF_ID = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (perf_clear) begin
      stall_count <= '0;
    end else if (stall_PC && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_control.sv
// Directed bench for hazard_stall_control: a DIV_CYCLES=4 instance for the short divide
// cases and a DIV_CYCLES=32, 6-bit counter instance for reset-abort and saturation.
module tb_hazard_stall_control;
  import hazard_stall_control_pkg::*;

  // Control vector order: stall_PC, stall_IF_ID, stall_ID_EX, flush_IF_ID,
  // flush_ID_EX, flush_EX_MEM, div_busy, div_done.
  localparam logic [7:0] C_IDLE = 8'b0000_0000;
  localparam logic [7:0] C_DIV  = 8'b1110_0110;
  localparam logic [7:0] C_LU   = 8'b1100_1000;
  localparam logic [7:0] C_BR   = 8'b0001_0000;
  localparam logic [7:0] C_DONE = 8'b0000_0001;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [REG_ADDR_WIDTH-1:0] rs, rt, target;
  logic                      rd1, rd2, wreg, mread, dstart, btaken, pclr;

  logic [7:0]  ctl_a, ctl_b;
  logic [31:0] count_a;
  logic [5:0]  count_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_stall_control #(.DIV_CYCLES(4), .CNT_WIDTH(8), .PERF_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst),
    .reg_data_1_addr_ID(rs), .reg_data_2_addr_ID(rt),
    .read_1_ID(rd1), .read_2_ID(rd2),
    .target_EX(target), .WriteReg_EX(wreg), .MemRead_EX(mread),
    .div_start_EX(dstart), .branch_taken_ID(btaken), .perf_clear(pclr),
    .stall_PC(ctl_a[7]), .stall_IF_ID(ctl_a[6]), .stall_ID_EX(ctl_a[5]),
    .flush_IF_ID(ctl_a[4]), .flush_ID_EX(ctl_a[3]), .flush_EX_MEM(ctl_a[2]),
    .div_busy(ctl_a[1]), .div_done(ctl_a[0]), .stall_count(count_a)
  );

  hazard_stall_control #(.DIV_CYCLES(32), .CNT_WIDTH(8), .PERF_WIDTH(6)) dut_b (
    .clk(clk), .rst(rst),
    .reg_data_1_addr_ID(rs), .reg_data_2_addr_ID(rt),
    .read_1_ID(rd1), .read_2_ID(rd2),
    .target_EX(target), .WriteReg_EX(wreg), .MemRead_EX(mread),
    .div_start_EX(dstart), .branch_taken_ID(btaken), .perf_clear(pclr),
    .stall_PC(ctl_b[7]), .stall_IF_ID(ctl_b[6]), .stall_ID_EX(ctl_b[5]),
    .flush_IF_ID(ctl_b[4]), .flush_ID_EX(ctl_b[3]), .flush_EX_MEM(ctl_b[2]),
    .div_busy(ctl_b[1]), .div_done(ctl_b[0]), .stall_count(count_b)
  );

  // ---------------- clock/reset and driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs = '0; rt = '0; target = '0;
    rd1 = 0; rd2 = 0; wreg = 0; mread = 0; dstart = 0; btaken = 0; pclr = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic drive_load(input logic [REG_ADDR_WIDTH-1:0] dst);
    mread = 1; wreg = 1; target = dst;
  endtask

  // One-cycle div_start on dut_b, then run through all 32 divide cycles.
  task automatic b_divide();
    dstart = 1;
    for (int i = 0; i < 32; i++) begin
      next_cycle();
      dstart = 0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    dstart = 1; btaken = 1; drive_load(5'd5); rd1 = 1; rs = 5'd5;
    @(negedge clk);
    tests++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL reset_ctl_a got=%b exp=%b", ctl_a, C_IDLE); end
    tests++;
    if (ctl_b !== C_IDLE) begin fails++; $display("FAIL reset_ctl_b got=%b exp=%b", ctl_b, C_IDLE); end
    tests++;
    if (count_a !== 32'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count_a); end
    next_cycle();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl_a, C_IDLE); end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive_load(5'd5); rd1 = 1; rs = 5'd5;
    @(negedge clk);
    tests++;
    if (ctl_a !== C_LU) begin fails++; $display("FAIL load_use_rs got=%b exp=%b", ctl_a, C_LU); end
    next_cycle();
    mread = 0; wreg = 0; target = '0;
    @(negedge clk);
    tests++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL load_use_bubble got=%b exp=%b", ctl_a, C_IDLE); end
    tests++;
    if (count_a !== 32'd1) begin fails++; $display("FAIL load_use_count got=%0d exp=1", count_a); end
    next_cycle();
    idle_inputs();
    drive_load(5'd7); rd2 = 1; rt = 5'd7; rs = 5'd3; rd1 = 1;
    @(negedge clk);
    tests++;
    if (ctl_a !== C_LU) begin fails++; $display("FAIL load_use_rt got=%b exp=%b", ctl_a, C_LU); end
    next_cycle();
  endtask

  task automatic test_no_hazard();
    apply_reset();
    drive_load(5'd0); rd1 = 1; rs = 5'd0;
    @(negedge clk);
    tests++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL no_hazard_r0 got=%b exp=%b", ctl_a, C_IDLE); end
    next_cycle();
    drive_load(5'd5); rd1 = 0; rs = 5'd5;
    @(negedge clk);
    tests++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL no_hazard_noread got=%b exp=%b", ctl_a, C_IDLE); end
    next_cycle();
    rd1 = 1; mread = 0;
    @(negedge clk);
    tests++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL no_hazard_noload got=%b exp=%b", ctl_a, C_IDLE); end
    next_cycle();
    tests++;
    if (count_a !== 32'd0) begin fails++; $display("FAIL no_hazard_count got=%0d exp=0", count_a); end
  endtask

  task automatic test_divide();
    apply_reset();
    dstart = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (ctl_a !== ((c < 3) ? C_DIV : C_DONE)) begin
        fails++;
        $display("FAIL divide_cycle%0d got=%b exp=%b", c, ctl_a, (c < 3) ? C_DIV : C_DONE);
      end
      next_cycle();
    end
    dstart = 0;
    @(negedge clk);
    tests++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL divide_after got=%b exp=%b", ctl_a, C_IDLE); end
    tests++;
    if (count_a !== 32'd3) begin fails++; $display("FAIL divide_count got=%0d exp=3", count_a); end
  endtask

  task automatic test_priority();
    apply_reset();
    dstart = 1; btaken = 1; drive_load(5'd9); rd1 = 1; rs = 5'd9;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (ctl_a !== C_DIV) begin fails++; $display("FAIL prio_div_cycle%0d got=%b exp=%b", c, ctl_a, C_DIV); end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    tests++;
    if (ctl_a !== C_DONE) begin fails++; $display("FAIL prio_div_release got=%b exp=%b", ctl_a, C_DONE); end
    next_cycle();
    btaken = 1; drive_load(5'd9); rd1 = 1; rs = 5'd9;
    @(negedge clk);
    tests++;
    if (ctl_a !== C_LU) begin fails++; $display("FAIL prio_load_use got=%b exp=%b", ctl_a, C_LU); end
    next_cycle();
    idle_inputs();
    btaken = 1;
    @(negedge clk);
    tests++;
    if (ctl_a !== C_BR) begin fails++; $display("FAIL prio_branch got=%b exp=%b", ctl_a, C_BR); end
    next_cycle();
    btaken = 0;
    @(negedge clk);
    tests++;
    if (ctl_a !== C_IDLE) begin fails++; $display("FAIL prio_branch_after got=%b exp=%b", ctl_a, C_IDLE); end
  endtask

  task automatic test_reset_mid_div();
    apply_reset();
    dstart = 1;
    @(negedge clk);
    tests++;
    if (ctl_b !== C_DIV) begin fails++; $display("FAIL abort_cycle0 got=%b exp=%b", ctl_b, C_DIV); end
    next_cycle();
    dstart = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (ctl_b !== C_IDLE) begin fails++; $display("FAIL abort_in_reset got=%b exp=%b", ctl_b, C_IDLE); end
    tests++;
    if (count_b !== 6'd0) begin fails++; $display("FAIL abort_count got=%0d exp=0", count_b); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (ctl_b !== C_IDLE) begin fails++; $display("FAIL abort_after got=%b exp=%b", ctl_b, C_IDLE); end
    next_cycle();
    dstart = 1;
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      tests++;
      if (ctl_b !== ((c < 31) ? C_DIV : (c == 31) ? C_DONE : C_IDLE)) begin
        fails++;
        $display("FAIL fresh_div_cycle%0d got=%b", c, ctl_b);
      end
      next_cycle();
      dstart = 0;
    end
    tests++;
    if (count_b !== 6'd31) begin fails++; $display("FAIL fresh_div_count got=%0d exp=31", count_b); end
  endtask

  task automatic test_saturation();
    b_divide();
    tests++;
    if (count_b !== 6'd62) begin fails++; $display("FAIL sat_second got=%0d exp=62", count_b); end
    b_divide();
    tests++;
    if (count_b !== 6'd63) begin fails++; $display("FAIL sat_third got=%0d exp=63", count_b); end
    dstart = 1; pclr = 1;
    @(negedge clk);
    tests++;
    if (ctl_b !== C_DIV) begin fails++; $display("FAIL clear_stalling got=%b exp=%b", ctl_b, C_DIV); end
    next_cycle();
    dstart = 0;
    tests++;
    if (count_b !== 6'd0) begin fails++; $display("FAIL clear_with_stall got=%0d exp=0", count_b); end
    pclr = 0;
    next_cycle();
    tests++;
    if (count_b !== 6'd1) begin fails++; $display("FAIL count_after_clear got=%0d exp=1", count_b); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_divide();
    test_priority();
    test_reset_mid_div();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
